// File: rtl/seg_display_arbiter_if.sv
// Requester-side bundle for the seven-segment display arbiter.
// The master drives requests and data; the slave (arbiter) drives the display side.
interface seg_display_arbiter_if #(
   parameter int NUM_SRC = 4,
   parameter int ID_W    = 2
);
   logic [NUM_SRC-1:0]    req;
   logic [16*NUM_SRC-1:0] src_data;
   logic                  pin;
   logic                  lz_en;
   logic [NUM_SRC-1:0]    grant;
   logic [ID_W-1:0]       src_id;
   logic [15:0]           display_value;
   logic [3:0]            blank;
   logic                  disp_valid;
   logic                  switch_pulse;

   modport master (
      output req, src_data, pin, lz_en,
      input  grant, src_id, display_value, blank,
      input  disp_valid, switch_pulse
   );

   modport slave (
      input  req, src_data, pin, lz_en,
      output grant, src_id, display_value, blank,
      output disp_valid, switch_pulse
   );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin scheduler sharing one 4-digit seven-segment display
// between NUM_SRC requesters, with dwell timing and leading-zero blanking.
module seg_display_arbiter #(
   parameter int NUM_SRC      = 4,
   parameter int ID_W         = 2,
   parameter int DWELL_CYCLES = 100_000_000
) (
   input logic                clk,
   input logic                rst_n,
   seg_display_arbiter_if.slave bus
);
   localparam int CW = $clog2(DWELL_CYCLES);
   localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL_CYCLES - 1);
   localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_SRC - 1);

   typedef enum logic {IDLE, SHOW} state_t;

   state_t             state, state_n;
   logic [ID_W-1:0]    sel, sel_n, ptr, ptr_n, nxt, w_ptr, w_nxt;
   logic [CW-1:0]      cnt, cnt_n;
   logic [NUM_SRC-1:0] grant, grant_n;
   logic [15:0]        value, value_n;
   logic [3:0]         blank, blank_n;
   logic               pulse, pulse_n;

   // First requester at or after start, wrapping modulo NUM_SRC
   function automatic logic [ID_W-1:0] pick(
      input logic [ID_W-1:0]    start,
      input logic [NUM_SRC-1:0] r
   );
      logic [ID_W-1:0] w;
      int              idx;
      w = start;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         idx = (int'(start) + k) % NUM_SRC;
         if (r[idx]) w = ID_W'(idx);
      end
      return w;
   endfunction

   function automatic logic [3:0] blank_of(
      input logic [15:0] v,
      input logic        lz
   );
      logic [3:0] b;
      b    = 4'b0000;
      b[3] = lz & (v[15:12] == 4'h0);
      b[2] = b[3] & (v[11:8] == 4'h0);
      b[1] = b[2] & (v[7:4] == 4'h0);
      return b;
   endfunction

   assign nxt   = (sel == LAST_ID) ? '0 : sel + 1'b1;
   assign w_ptr = pick(ptr, bus.req);
   assign w_nxt = pick(nxt, bus.req);

   always_comb begin
      state_n = state;
      sel_n   = sel;
      ptr_n   = ptr;
      cnt_n   = cnt;
      value_n = value;
      pulse_n = 1'b0;
      unique case (state)
         IDLE: begin
            if (|bus.req) begin
               sel_n   = w_ptr;
               value_n = bus.src_data[16*int'(w_ptr) +: 16];
               cnt_n   = '0;
               pulse_n = 1'b1;
               state_n = SHOW;
            end
         end
         SHOW: begin
            value_n = bus.src_data[16*int'(sel) +: 16];
            if (!bus.req[sel]) begin
               ptr_n = nxt;
               if (|bus.req) begin
                  sel_n   = w_nxt;
                  value_n = bus.src_data[16*int'(w_nxt) +: 16];
                  cnt_n   = '0;
                  pulse_n = 1'b1;
               end else begin
                  value_n = value;
                  state_n = IDLE;
               end
            end else if (bus.pin) begin
               cnt_n = cnt;
            end else if (cnt == LAST_CNT) begin
               ptr_n   = nxt;
               cnt_n   = '0;
               sel_n   = w_nxt;
               value_n = bus.src_data[16*int'(w_nxt) +: 16];
               pulse_n = (w_nxt != sel);
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      // Display-side registers follow the state being entered
      grant_n = '0;
      blank_n = 4'b1111;
      if (state_n == SHOW) begin
         grant_n = NUM_SRC'(1) << sel_n;
         blank_n = blank_of(value_n, bus.lz_en);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sel   <= '0;
         ptr   <= '0;
         cnt   <= '0;
         grant <= '0;
         value <= '0;
         blank <= 4'b1111;
         pulse <= 1'b0;
      end else begin
         state <= state_n;
         sel   <= sel_n;
         ptr   <= ptr_n;
         cnt   <= cnt_n;
         grant <= grant_n;
         value <= value_n;
         blank <= blank_n;
         pulse <= pulse_n;
      end
   end

   assign bus.grant         = grant;
   assign bus.src_id        = sel;
   assign bus.display_value = value;
   assign bus.blank         = blank;
   assign bus.disp_valid    = (state == SHOW);
   assign bus.switch_pulse  = pulse;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter: a cycle model queues the
// expected display state each edge, directed checks cover the key scenarios.
module tb_seg_display_arbiter;
   localparam int N = 4;
   localparam int D = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_run = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   seg_display_arbiter_if #(.NUM_SRC(N), .ID_W(2)) bus ();

   seg_display_arbiter #(
      .NUM_SRC(N), .ID_W(2), .DWELL_CYCLES(D)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );

   typedef struct packed {
      logic [3:0]  grant;
      logic [1:0]  id;
      logic [15:0] val;
      logic [3:0]  blank;
      logic        valid;
      logic        pulse;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   int         m_sel, m_ptr, m_cnt;
   bit         m_show, m_pulse;
   logic [15:0] m_val;

   function automatic int first_req(input int start, input logic [N-1:0] r);
      int i;
      i = start;
      repeat (N) begin
         if (r[i]) return i;
         i = (i + 1) % N;
      end
      return start;
   endfunction

   function automatic logic [3:0] exp_blank(input logic [15:0] v,
                                            input logic lz);
      logic [3:0] b;
      int         zeros;
      b = 4'b0000;
      zeros = 0;
      if (!lz) return b;
      for (int n = 3; n >= 1; n--) begin
         if (v[4*n +: 4] != 4'h0) break;
         zeros++;
      end
      for (int k = 1; k <= 3; k++)
         if (k >= 4 - zeros) b[k] = 1'b1;
      return b;
   endfunction

   function automatic logic [15:0] dat(input int i);
      logic [63:0] d;
      d = bus.src_data;
      return d[16*i +: 16];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      exp_t e;
      int   n;
      if (!rst_n) begin
         m_show = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
         m_val = '0; m_pulse = 0;
         sb.delete();
      end else begin
         m_pulse = 0;
         if (!m_show) begin
            if (|bus.req) begin
               m_sel = first_req(m_ptr, bus.req);
               m_cnt = 0; m_pulse = 1; m_show = 1;
               m_val = dat(m_sel);
            end
         end else if (!bus.req[m_sel]) begin
            m_ptr = (m_sel + 1) % N;
            if (|bus.req) begin
               m_sel = first_req(m_ptr, bus.req);
               m_cnt = 0; m_pulse = 1;
               m_val = dat(m_sel);
            end else begin
               m_show = 0;
            end
         end else begin
            if (!bus.pin) begin
               if (m_cnt == D - 1) begin
                  m_ptr = (m_sel + 1) % N;
                  m_cnt = 0;
                  n = first_req(m_ptr, bus.req);
                  m_pulse = (n != m_sel);
                  m_sel = n;
               end else begin
                  m_cnt++;
               end
            end
            m_val = dat(m_sel);
         end
         e.grant = m_show ? 4'(1 << m_sel) : 4'b0000;
         e.id    = 2'(m_sel);
         e.val   = m_val;
         e.blank = m_show ? exp_blank(m_val, bus.lz_en) : 4'b1111;
         e.valid = m_show;
         e.pulse = m_pulse;
         sb.push_back(e);
      end
   end

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n && sb.size() > 0) begin
         e = sb.pop_front();
         chk("sb_grant", 32'(bus.grant), 32'(e.grant));
         chk("sb_src_id", 32'(bus.src_id), 32'(e.id));
         chk("sb_value", 32'(bus.display_value), 32'(e.val));
         chk("sb_blank", 32'(bus.blank), 32'(e.blank));
         chk("sb_valid", 32'(bus.disp_valid), 32'(e.valid));
         chk("sb_pulse", 32'(bus.switch_pulse), 32'(e.pulse));
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req = '0;
      bus.pin = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_grant(input logic [3:0] g);
      int t;
      t = 0;
      while (bus.grant !== g && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("wait_grant", 32'(bus.grant), 32'(g));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.req = '0;
      bus.src_data = '0;
      bus.pin = 1'b0;
      bus.lz_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_grant", 32'(bus.grant), 32'h0);
      chk("rst_blank", 32'(bus.blank), 32'hF);
      chk("rst_valid", 32'(bus.disp_valid), 32'h0);
      chk("rst_value", 32'(bus.display_value), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single source
      @(negedge clk);
      bus.src_data[15:0] = 16'h00A5;
      bus.req = 4'b0001;
      tick();
      chk("single_grant", 32'(bus.grant), 32'h1);
      chk("single_value", 32'(bus.display_value), 32'h00A5);
      chk("single_blank", 32'(bus.blank), 32'hC);
      chk("single_pulse", 32'(bus.switch_pulse), 32'h1);
      repeat (12) tick();
      chk("single_hold", 32'(bus.grant), 32'h1);

      // Reset mid-show, outputs drop immediately
      @(negedge clk);
      rst_n = 1'b0;
      bus.req = '0;
      #1;
      chk("amid_grant", 32'(bus.grant), 32'h0);
      chk("amid_blank", 32'(bus.blank), 32'hF);
      chk("amid_valid", 32'(bus.disp_valid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("idle_after_rst", 32'(bus.disp_valid), 32'h0);

      // Rotation over 0,1,3
      @(negedge clk);
      bus.src_data = 64'h4444_3333_2222_1111;
      bus.req = 4'b1011;
      repeat (40) @(posedge clk);

      // Withdrawal of source 1 at count 3
      wait_grant(4'b1000);
      wait_grant(4'b0010);
      repeat (3) @(posedge clk);
      @(negedge clk);
      bus.req = 4'b1001;
      tick();
      chk("wd_grant", 32'(bus.grant), 32'h8);
      chk("wd_pulse", 32'(bus.switch_pulse), 32'h1);
      @(negedge clk);
      bus.req = 4'b0010;
      wait_grant(4'b0010);
      @(negedge clk);
      bus.req = 4'b0000;
      tick();
      chk("wd_idle_blank", 32'(bus.blank), 32'hF);
      chk("wd_idle_grant", 32'(bus.grant), 32'h0);

      // Pin at count 5
      do_reset();
      @(negedge clk);
      bus.req = 4'b0011;
      @(posedge clk);
      repeat (5) @(posedge clk);
      @(negedge clk);
      bus.pin = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("pin_hold", 32'(bus.grant), 32'h1);
      @(negedge clk);
      bus.pin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("pin_cnt7", 32'(bus.grant), 32'h1);
      tick();
      chk("pin_switch", 32'(bus.grant), 32'h2);
      chk("pin_pulse", 32'(bus.switch_pulse), 32'h1);

      // Live tracking and blanking
      do_reset();
      @(negedge clk);
      bus.lz_en = 1'b1;
      bus.src_data = '0;
      bus.req = 4'b0001;
      tick();
      chk("live_0000", 32'(bus.blank), 32'hE);
      @(negedge clk);
      bus.src_data[15:0] = 16'h0F00;
      tick();
      chk("live_0f00_v", 32'(bus.display_value), 32'h0F00);
      chk("live_0f00_b", 32'(bus.blank), 32'h8);
      @(negedge clk);
      bus.src_data[15:0] = 16'h1234;
      tick();
      chk("live_1234_v", 32'(bus.display_value), 32'h1234);
      chk("live_1234_b", 32'(bus.blank), 32'h0);
      @(negedge clk);
      bus.lz_en = 1'b0;
      bus.src_data[15:0] = 16'h0000;
      tick();
      chk("live_nolz_b", 32'(bus.blank), 32'h0);

      // Random traffic against the model
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 5) == 0) bus.req = 4'($urandom);
         bus.pin = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 3) == 0)
            bus.src_data = {$urandom, $urandom};
         if ($urandom_range(0, 15) == 0) bus.lz_en = ~bus.lz_en;
      end
      @(negedge clk);
      bus.req = '0;
      bus.pin = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Round-robin arbiter and scheduler that shares the single 4-digit seven-segment display between NUM_SRC requesters.
- Each requester holds a request and presents a 16-bit hex value.
- The arbiter grants one source at a time and shows it for a fixed dwell period, then rotates to the next requester.
- Its outputs (display_value, blank) feed the seven-segment multiplex driver directly. It also produces leading-zero blanking.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- ID_W, 2, width of src_id; NUM_SRC <= 2**ID_W.
- DWELL_CYCLES, 100_000_000, clock cycles one source is shown before rotation (>= 2); benches use 8.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_SRC  per-source display request, level, held while the source wants the display.
- src_data  in  16*NUM_SRC  source i value at bits [16*i+15:16*i].
- pin  in  1  freeze rotation on the current source while high.
- lz_en  in  1  enable leading-zero blanking.
- grant  out  NUM_SRC  one-hot grant to the source being displayed; all-zero when idle.
- src_id  out  ID_W  index of the granted source.
- display_value  out  16  value to the multiplex driver.
- blank  out  4  per-digit blank, bit k = digit k (nibble k); 1 = digit off.
- disp_valid  out  1  high while a source is granted.
- switch_pulse  out  1  one-cycle pulse on every new grant or source change.

Behaviour:
- Reset (async, rst_n=0), all outputs forced immediately:
  - grant=0, src_id=0, display_value=0, blank=4'b1111, disp_valid=0, switch_pulse=0.
  - Rotation pointer ptr=0, dwell_cnt=0, state=IDLE.
- Reset mid-SHOW aborts the display; no pulse on release.
- Winner function: w = first index i, scanning ptr, ptr+1, ... modulo NUM_SRC, with req[i]=1. It is evaluated from req in the current cycle.

State IDLE:
- Outputs: grant=0, disp_valid=0, blank=1111. display_value holds its last value.
- If |req on a rising edge:
  - sel<=w, grant<=onehot(w), src_id<=w, display_value<=src_data[w].
  - dwell_cnt<=0, switch_pulse<=1, state<=SHOW.
- Latency: req rise to grant is 1 cycle.

State SHOW, evaluated each edge in priority order:
1. req[sel]=0 (source withdrew):
   - ptr<=sel+1 (mod NUM_SRC).
   - If another source requests, grant it on the same edge with the winner computed from the new pointer (no idle gap) and switch_pulse=1.
   - Otherwise go to IDLE.
2. pin=1: dwell_cnt holds its value and no rotation occurs. display_value tracks the source live.
3. dwell_cnt==DWELL_CYCLES-1:
   - ptr<=sel+1.
   - If any other source requests, switch to the winner from sel+1, with dwell_cnt<=0 and switch_pulse=1.
   - If only sel requests, keep sel with dwell_cnt<=0 and no pulse.
4. Else dwell_cnt<=dwell_cnt+1.
- In SHOW, display_value<=src_data[sel] every cycle (live tracking, 1-cycle latency). On a switch edge it loads the new source's data.
- disp_valid=1 throughout SHOW.
- switch_pulse is high exactly one cycle after each grant change, else 0.

Blanking:
- Registered in the same cycle as display_value and computed from the value being loaded (v).
- Bit 0 is always 0 in SHOW.
- With lz_en=1:
  - blank[3] = (v[15:12]==0)
  - blank[2] = blank[3] & (v[11:8]==0)
  - blank[1] = blank[2] & (v[7:4]==0)
- With lz_en=0: blank=4'b0000.
- Value 0 therefore shows a single "0".

Other rules:
- dwell_cnt width is clog2(DWELL_CYCLES). It never exceeds DWELL_CYCLES-1 and wraps only via the rules above.
- Simultaneous request rises: the lowest index at or after ptr wins. Starvation-free: every holding requester is granted within NUM_SRC dwell periods (pin low).
- Pin released mid-dwell: counting resumes from the held count.

Test Plan:
- Reset: assert rst_n=0 mid-SHOW -> grant=0, blank=1111, disp_valid=0 in the same cycle; after release with req=0, stays IDLE.
- Single source (DWELL=8): req=0001, src_data0=16'h00A5, lz_en=1
  - one cycle later: grant=0001, src_id=0, display_value=00A5, blank=1100, switch_pulse for one cycle.
  - at dwell end: no pulse, grant held.
- Rotation: req=1011 held, values 1111/2222/-/4444 -> grants cycle 0001, 0010, 1000, 0001, each lasting exactly 8 cycles, with switch_pulse at every change and no gap cycles.
- Withdrawal: while source 1 is shown, drop req[1] at dwell count 3 -> next edge grants source 3; with req=0010 only, it goes to IDLE, blank=1111.
- Pin: pin=1 at count 5 with req=0011 -> source 0 held for 20 cycles; after pin=0, switches after 2 more cycles (counts 6, 7).
- Live/blank: shown source data changes 0000 -> 0F00 -> 1234 -> display_value follows one cycle later.
  - lz_en=1: blank goes 1110, then 1000, then 0000.
  - lz_en=0: blank=0000.
